// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared scan-controller state encoding, geometry constants and hex segment table
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_t;

    localparam int NUM_DIGITS = 4;
    localparam int NUM_COLS   = 5;
    localparam int NUM_ROWS   = 7;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // {a,b,c,d,e,f,g}, a in bit 6
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'b1111110;
            4'h1:    seg = 7'b0110000;
            4'h2:    seg = 7'b1101101;
            4'h3:    seg = 7'b1111001;
            4'h4:    seg = 7'b0110011;
            4'h5:    seg = 7'b1011011;
            4'h6:    seg = 7'b1011111;
            4'h7:    seg = 7'b1110000;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1111011;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b0011111;
            4'hC:    seg = 7'b1001110;
            4'hD:    seg = 7'b0111101;
            4'hE:    seg = 7'b1001111;
            default: seg = 7'b1000111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational hex nibble to {a..g} segment decoder
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed 4-digit 7-segment and 5x7 matrix scan controller
// Define SCAN_BLANKING_EN to insert a dark slot after every lit slot.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] digit_val,
    input  logic [3:0]  digit_blank,
    input  logic [34:0] mat_data,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic        d01,
    output logic        d02,
    output logic        d03,
    output logic        d04,
    output logic [4:0]  coluna,
    output logic [6:0]  linha,
    output logic        frame_done
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    scan_state_t state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_idx_q, digit_idx_d;
    logic [2:0]    col_idx_q, col_idx_d;
    logic [15:0]   digit_sh_q, digit_sh_d;
    logic [3:0]    blank_sh_q, blank_sh_d;
    logic [34:0]   mat_sh_q, mat_sh_d;

    logic [6:0]          seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic [NUM_COLS-1:0] col_q, col_d;
    logic [NUM_ROWS-1:0] row_q, row_d;
    logic                frame_done_q, frame_done_d;

    logic tick;
    logic advance;
    logic load_shadow;
    logic [3:0] nibble;
    logic [6:0] dec_seg;
    logic [NUM_ROWS-1:0] row_sel;

    always_comb begin
        tick         = (presc_q == PRESC_MAX);
        state_d      = state_q;
        presc_d      = presc_q;
        digit_idx_d  = digit_idx_q;
        col_idx_d    = col_idx_q;
        digit_sh_d   = digit_sh_q;
        blank_sh_d   = blank_sh_q;
        mat_sh_d     = mat_sh_q;
        frame_done_d = 1'b0;
        advance      = 1'b0;
        load_shadow  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                if (enable) begin
                    state_d     = ST_SCAN;
                    digit_idx_d = '0;
                    col_idx_d   = '0;
                    load_shadow = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
`ifdef SCAN_BLANKING_EN
                        state_d = ST_BLANK;
`else
                        advance = 1'b1;
`endif
                    end
                end
            end
`ifdef SCAN_BLANKING_EN
            ST_BLANK: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        state_d = ST_SCAN;
                        advance = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
            end
        endcase

        // Digit and column counters wrap independently (4 vs 5 slots).
        if (advance) begin
            digit_idx_d = digit_idx_q + 2'd1;
            col_idx_d   = (col_idx_q == 3'(NUM_COLS - 1)) ? 3'd0 : col_idx_q + 3'd1;
            if (digit_idx_q == 2'(NUM_DIGITS - 1)) begin
                frame_done_d = 1'b1;
                load_shadow  = 1'b1;
            end
        end

        if (load_shadow) begin
            digit_sh_d = digit_val;
            blank_sh_d = digit_blank;
            mat_sh_d   = mat_data;
        end
    end

    assign nibble = 4'(digit_sh_q >> {digit_idx_q, 2'b00});

    seg7_decoder u_seg7_decoder (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        row_sel = '0;
        for (int k = 0; k < NUM_COLS; k++) begin
            if (col_idx_q == 3'(k)) begin
                row_sel = mat_sh_q[NUM_ROWS*k +: NUM_ROWS];
            end
        end
    end

    // Outputs follow the registered state, so they lag index/state changes by one cycle.
    always_comb begin
        seg_d = SEG_BLANK;
        dig_d = '0;
        col_d = '0;
        row_d = '0;
        if (state_q == ST_SCAN) begin
            if (!blank_sh_q[digit_idx_q]) begin
                seg_d = dec_seg;
                dig_d = 4'b0001 << digit_idx_q;
            end
            col_d = 5'b00001 << col_idx_q;
            row_d = row_sel;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            digit_idx_q  <= '0;
            col_idx_q    <= '0;
            digit_sh_q   <= '0;
            blank_sh_q   <= 4'b1111;
            mat_sh_q     <= '0;
            seg_q        <= SEG_BLANK;
            dig_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            digit_idx_q  <= digit_idx_d;
            col_idx_q    <= col_idx_d;
            digit_sh_q   <= digit_sh_d;
            blank_sh_q   <= blank_sh_d;
            mat_sh_q     <= mat_sh_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;
    assign {d04, d03, d02, d01}  = dig_q;
    assign coluna                = col_q;
    assign linha                 = row_q;
    assign frame_done            = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl (TICK_DIV=4)
module tb_display_scan_ctrl;

    localparam int TD = 4;
`ifdef SCAN_BLANKING_EN
    localparam int BL = 1;
`else
    localparam int BL = 0;
`endif
    localparam int SL = (BL != 0) ? 2 * TD : TD;
    localparam int FL = 4 * SL;

    logic        clock = 1'b0;
    logic        reset, enable;
    logic [15:0] digit_val;
    logic [3:0]  digit_blank;
    logic [34:0] mat_data;
    logic        a, b, c, d, e, f, g;
    logic        d01, d02, d03, d04;
    logic [4:0]  coluna;
    logic [6:0]  linha;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int fd_count = 0;

    display_scan_ctrl #(.TICK_DIV(TD)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .digit_val(digit_val), .digit_blank(digit_blank), .mat_data(mat_data),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .d01(d01), .d02(d02), .d03(d03), .d04(d04),
        .coluna(coluna), .linha(linha), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    wire [6:0]  seg_w   = {a, b, c, d, e, f, g};
    wire [3:0]  dig_w   = {d04, d03, d02, d01};
    wire [23:0] dut_vec = {seg_w, dig_w, coluna, linha, frame_done};

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1111110;  4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;  4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;  4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;  4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;  4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;  4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;  4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;  default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // Time-based model: outputs depend only on cycles elapsed since the scan started.
    logic        m_run = 1'b0;
    int          m_t = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_blank = 4'hF;
    logic [34:0] m_mat = '0;
    logic [23:0] exp_vec = '0;
    logic        model_on = 1'b0;
    logic [23:0] v;
    int          ph, slot, dg, cl;

    always @(posedge clock) begin
        v = '0;
        if (!reset && m_run) begin
            ph   = m_t / TD;
            slot = (BL != 0) ? ph / 2 : ph;
            if (!((BL != 0) && (ph % 2 == 1))) begin
                dg = slot % 4;
                cl = slot % 5;
                if (!m_blank[dg]) begin
                    v[23:17] = hex7(4'(m_val >> (4 * dg)));
                    v[13 + dg] = 1'b1;
                end
                v[8 + cl] = 1'b1;
                v[7:1] = 7'(m_mat >> (7 * cl));
            end
            if (enable && ((m_t + 1) % FL == 0)) v[0] = 1'b1;
        end
        exp_vec = v;

        if (reset) begin
            m_run = 1'b0; m_val = '0; m_blank = 4'hF; m_mat = '0;
        end else if (!m_run) begin
            if (enable) begin
                m_run = 1'b1; m_t = 0;
                m_val = digit_val; m_blank = digit_blank; m_mat = mat_data;
            end
        end else if (!enable) begin
            m_run = 1'b0;
        end else begin
            m_t++;
            if (m_t % FL == 0) begin
                m_val = digit_val; m_blank = digit_blank; m_mat = mat_data;
            end
        end
        model_on = 1'b1;
    end

    always @(negedge clock) begin
        if (model_on) begin
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, dut_vec, exp_vec);
            end
        end
        if (reset && frame_done) fd_count++;
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; digit_val = '0; digit_blank = '0;
        mat_data = {7'h40, 7'h01, 7'h7F, 7'h2A, 7'h55};
        repeat (5) @(negedge clock);
        lit("reset_outputs", 32'(dut_vec), 32'h0);
        lit("reset_no_frame_done", fd_count, 0);

        reset = 1'b0; digit_val = 16'h3210;
        @(negedge clock);
        enable = 1'b1;
        for (int n = 1; n <= 16 * SL + 4; n++) begin
            @(negedge clock);
            if (n == 2) begin
                lit("slot0_seg", 32'(seg_w), 32'b1111110);
                lit("slot0_dig", 32'(dig_w), 32'b0001);
                lit("slot0_col", 32'(coluna), 32'b00001);
                lit("slot0_row", 32'(linha), 32'b1010101);
            end
`ifdef SCAN_BLANKING_EN
            if (n == TD + 2) lit("blank_gap", 32'(dut_vec), 32'h0);
`endif
            if (n == SL + 2) begin
                lit("slot1_seg", 32'(seg_w), 32'b0110000);
                lit("slot1_dig", 32'(dig_w), 32'b0010);
                lit("slot1_row", 32'(linha), 32'b0101010);
            end
            if (n == 2 * SL + 2) lit("slot2_seg", 32'(seg_w), 32'b1101101);
            if (n == 3 * SL + 2) begin
                lit("slot3_seg", 32'(seg_w), 32'b1111001);
                lit("slot3_dig", 32'(dig_w), 32'b1000);
            end
            if (n == 4 * SL) lit("fd_before_wrap", 32'(frame_done), 32'h0);
            if (n == 4 * SL + 1) lit("fd_at_wrap", 32'(frame_done), 32'h1);
            if (n == 4 * SL + 2) begin
                lit("col_wrap_col4", 32'(coluna), 32'b10000);
                lit("col_wrap_dig0", 32'(dig_w), 32'b0001);
                lit("col4_row", 32'(linha), 32'b1000000);
                digit_val = 16'h8888;
            end
            if (n == 6 * SL + 2) lit("no_tear_seg", 32'(seg_w), 32'b1101101);
            if (n == 9 * SL + 2) begin
                lit("reload_8_seg", 32'(seg_w), 32'b1111111);
                digit_blank = 4'b0100;
            end
            if (n == 10 * SL + 2) lit("no_tear_blank", 32'(dig_w), 32'b0100);
            if (n == 14 * SL + 2) begin
                lit("blank_d03_dig", 32'(dig_w), 32'h0);
                lit("blank_d03_seg", 32'(seg_w), 32'h0);
                lit("blank_d03_col", 32'(coluna), 32'b10000);
            end
            if (n == 15 * SL + 2) lit("after_blank_seg", 32'(seg_w), 32'b1111111);
            if (n == 16 * SL) enable = 1'b0;
            if (n == 16 * SL + 1) lit("drop_no_fd", 32'(frame_done), 32'h0);
            if (n == 16 * SL + 2) lit("drop_outputs_zero", 32'(dut_vec), 32'h0);
        end

        enable = 1'b1;
        repeat (SL + 2) @(negedge clock);
        lit("mid_frame_d02", 32'(dig_w), 32'b0010);
        reset = 1'b1;
        @(negedge clock);
        lit("reset_mid_zero", 32'(dut_vec), 32'h0);
        reset = 1'b0;
        @(negedge clock);
        lit("restart_idle_zero", 32'(dut_vec), 32'h0);
        @(negedge clock);
        lit("restart_d01", 32'(dig_w), 32'b0001);
        lit("restart_col0", 32'(coluna), 32'b00001);
        repeat (2 * FL) @(negedge clock);
        enable = 1'b0;
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
